// File: rtl/framebuffer_swapchain_if.sv
// -----------------------------------------------------------------------------
// framebuffer_swapchain_if
// Bundles the draw, display, swap and clear signals of the double-buffered
// framebuffer. The host (GPU/CPU plus video timing) uses the master modport.
// The framebuffer uses the slave modport.
//
// Signal summary (direction seen from the framebuffer):
//   drawAddress     in   back-bank word address
//   drawDataIn      in   back-bank write data
//   drawWriteEnable in   back-bank write strobe (dropped while busy)
//   drawDataOut     out  registered back-bank read data
//   displayAddress  in   front-bank word address
//   displayDataOut  out  registered front-bank read data
//   vblank          in   vertical blank level
//   swapRequest     in   single-cycle swap request pulse
//   swapPending     out  swap requested, not yet executed
//   frontBank       out  bank currently scanned out
//   clearRequest    in   single-cycle clear start pulse
//   clearColour     in   fill value, sampled when the clear is accepted
//   busy            out  clear engine active
//   clearStateDbg   out  clear FSM state (0 = IDLE, 1 = CLEAR)
//
// Request semantics: there is no ready/valid pair. swapRequest and
// clearRequest are one-cycle pulses. A swap request is always remembered
// until it executes. A clear request is accepted only when the clear FSM is
// idle and is otherwise ignored, so the host watches busy before asking.
// -----------------------------------------------------------------------------
interface framebuffer_swapchain_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] drawAddress;
  logic [WIDTH-1:0]  drawDataIn;
  logic              drawWriteEnable;
  logic [WIDTH-1:0]  drawDataOut;
  logic [ADDR_W-1:0] displayAddress;
  logic [WIDTH-1:0]  displayDataOut;
  logic              vblank;
  logic              swapRequest;
  logic              swapPending;
  logic              frontBank;
  logic              clearRequest;
  logic [WIDTH-1:0]  clearColour;
  logic              busy;
  logic              clearStateDbg;

  modport master (
    output drawAddress, drawDataIn, drawWriteEnable, displayAddress,
           vblank, swapRequest, clearRequest, clearColour,
    input  drawDataOut, displayDataOut, swapPending, frontBank, busy,
           clearStateDbg
  );

  modport slave (
    input  drawAddress, drawDataIn, drawWriteEnable, displayAddress,
           vblank, swapRequest, clearRequest, clearColour,
    output drawDataOut, displayDataOut, swapPending, frontBank, busy,
           clearStateDbg
  );
endinterface

// File: rtl/framebuffer_swapchain.sv
// -----------------------------------------------------------------------------
// framebuffer_swapchain
// Double-buffered framebuffer. Storage holds two banks of DEPTH words each,
// addressed as {bank, word}. The display port reads the front bank. The draw
// port reads and writes the back bank (~frontBank). Bank swaps happen only on
// a vblank rising edge while the clear engine is idle. The clear engine fills
// the back bank with a latched colour, one word per cycle.
//
// Ports:
//   clk    in  system clock, all logic on posedge
//   reset  in  synchronous, active-high
//   bus    framebuffer_swapchain_if.slave (see the interface for signals)
// -----------------------------------------------------------------------------
module framebuffer_swapchain #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  framebuffer_swapchain_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clear_state_e;

  clear_state_e      state_q, state_d;
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic              vblank_prev_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  colour_q, colour_d;
  logic              clear_bank_q, clear_bank_d;
  logic [WIDTH-1:0]  draw_rd_q;
  logic [WIDTH-1:0]  disp_rd_q;

  logic [WIDTH-1:0]  mem [0:2*DEPTH-1];

  logic              vblank_rise;
  logic              swap_fire;
  logic              draw_we;
  logic              mem_we;
  logic [ADDR_W:0]   mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  assign vblank_rise = bus.vblank & ~vblank_prev_q;
  // A request in the same cycle as the edge counts, so a late pulse is not
  // pushed to the next frame.
  assign swap_fire   = vblank_rise & (pend_q | bus.swapRequest) & (state_q == S_IDLE);
  assign draw_we     = bus.drawWriteEnable & (state_q == S_IDLE);

  // Swap bookkeeping, clear FSM next state and the single memory write port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    colour_d     = colour_q;
    clear_bank_d = clear_bank_q;
    front_d      = front_q ^ swap_fire;
    pend_d       = swap_fire ? 1'b0 : (pend_q | bus.swapRequest);
    mem_we       = 1'b0;
    mem_waddr    = {~front_q, bus.drawAddress};
    mem_wdata    = bus.drawDataIn;

    unique case (state_q)
      S_IDLE: begin
        if (bus.clearRequest) begin
          state_d      = S_CLEAR;
          cnt_d        = '0;
          colour_d     = bus.clearColour;
          // Target the back bank as it will be after any swap this cycle.
          clear_bank_d = ~front_d;
        end
        if (draw_we) begin
          mem_we = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = {clear_bank_q, cnt_q};
        mem_wdata = colour_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      front_q       <= 1'b0;
      pend_q        <= 1'b0;
      vblank_prev_q <= 1'b0;
      cnt_q         <= '0;
      colour_q      <= '0;
      clear_bank_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      pend_q        <= pend_d;
      vblank_prev_q <= bus.vblank;
      cnt_q         <= cnt_d;
      colour_q      <= colour_d;
      clear_bank_q  <= clear_bank_d;
    end
  end

  // Storage is not reset; writes are suppressed during reset so a clear
  // aborted by reset leaves no word beyond those already written.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read registers. Both read with the pre-swap frontBank; the draw output
  // holds during an accepted draw write.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_rd_q <= '0;
      disp_rd_q <= '0;
    end else begin
      disp_rd_q <= mem[{front_q, bus.displayAddress}];
      if (!draw_we) begin
        draw_rd_q <= mem[{~front_q, bus.drawAddress}];
      end
    end
  end

  assign bus.drawDataOut    = draw_rd_q;
  assign bus.displayDataOut = disp_rd_q;
  assign bus.swapPending    = pend_q;
  assign bus.frontBank      = front_q;
  assign bus.busy           = (state_q == S_CLEAR);
  assign bus.clearStateDbg  = state_q;

endmodule

// File: tb/tb_framebuffer_swapchain.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_swapchain
// Directed bench for framebuffer_swapchain with DEPTH=16, WIDTH=9. Inputs are
// driven 1 ns after the rising edge; outputs are sampled at that same point,
// so each check reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_framebuffer_swapchain;
  localparam int WIDTH  = 9;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  framebuffer_swapchain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  framebuffer_swapchain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic draw_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    bus.drawAddress     = a;
    bus.drawDataIn      = d;
    bus.drawWriteEnable = 1'b1;
    tick();
    bus.drawWriteEnable = 1'b0;
  endtask

  int busy_cycles;

  initial begin
    checks = 0;
    errors = 0;
    bus.drawAddress     = '0;
    bus.drawDataIn      = '0;
    bus.drawWriteEnable = 1'b0;
    bus.displayAddress  = '0;
    bus.vblank          = 1'b0;
    bus.swapRequest     = 1'b0;
    bus.clearRequest    = 1'b0;
    bus.clearColour     = '0;
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_front",   bus.frontBank, 0);
    check("rst_pending", bus.swapPending, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_draw",    bus.drawDataOut, 0);
    check("rst_disp",    bus.displayDataOut, 0);
    reset = 1'b0;

    // Draw write then read back; display port sees the other bank
    draw_write(4'd5, 9'h1AB);
    bus.drawAddress    = 4'd5;
    bus.displayAddress = 4'd5;
    tick();
    check("draw_rd_5",      bus.drawDataOut, 9'h1AB);
    check("disp_not_1ab",   32'(bus.displayDataOut !== 9'h1AB), 1);
    check("front_still_0",  bus.frontBank, 0);

    // Swap request held pending while vblank is low
    bus.swapRequest = 1'b1;
    tick();
    bus.swapRequest = 1'b0;
    repeat (9) tick();
    check("pend_wait",  bus.swapPending, 1);
    check("front_wait", bus.frontBank, 0);
    bus.vblank = 1'b1;
    tick();
    check("swap_front", bus.frontBank, 1);
    check("swap_pend",  bus.swapPending, 0);
    tick();
    check("disp_after_swap", bus.displayDataOut, 9'h1AB);
    bus.vblank = 1'b0;
    tick();

    // Request coincident with the vblank rise; level-high vblank does not retrigger
    bus.vblank      = 1'b1;
    bus.swapRequest = 1'b1;
    tick();
    bus.swapRequest = 1'b0;
    check("same_cycle_front", bus.frontBank, 0);
    check("same_cycle_pend",  bus.swapPending, 0);
    repeat (3) tick();
    check("held_vblank_front", bus.frontBank, 0);
    bus.vblank = 1'b0;
    tick();

    // Clear bank 1 with 0x155; dropped draw write, swap request and vblank rise mid-clear
    bus.clearColour  = 9'h155;
    bus.clearRequest = 1'b1;
    tick();
    bus.clearRequest = 1'b0;
    check("clear_busy_start", bus.busy, 1);
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      bus.drawWriteEnable = (i == 12);
      bus.drawAddress     = 4'd2;
      bus.drawDataIn      = 9'h0F0;
      bus.swapRequest     = (i == 5);
      bus.vblank          = (i >= 7 && i < 9);
      tick();
      if (bus.busy) busy_cycles++;
    end
    bus.drawWriteEnable = 1'b0;
    bus.swapRequest     = 1'b0;
    bus.vblank          = 1'b0;
    check("clear_busy_len",   busy_cycles, 16);
    check("clear_no_swap",    bus.frontBank, 0);
    check("clear_pend_kept",  bus.swapPending, 1);
    for (int a = 0; a < DEPTH; a++) begin
      bus.drawAddress = ADDR_W'(a);
      tick();
      check($sformatf("clear_word_%0d", a), bus.drawDataOut, 9'h155);
    end

    // Deferred swap fires on the first vblank rise after the clear
    bus.vblank = 1'b1;
    tick();
    check("deferred_front", bus.frontBank, 1);
    check("deferred_pend",  bus.swapPending, 0);
    bus.vblank = 1'b0;
    tick();

    // Fill bank 0 with a pattern, then abort a clear with reset at word 4
    for (int a = 0; a < DEPTH; a++) begin
      draw_write(ADDR_W'(a), WIDTH'(9'h040 + a));
    end
    bus.clearColour  = 9'h0AA;
    bus.clearRequest = 1'b1;
    tick();
    bus.clearRequest = 1'b0;
    bus.swapRequest  = 1'b1;
    tick();
    bus.swapRequest  = 1'b0;
    repeat (3) tick();
    check("abort_pend_before", bus.swapPending, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",  bus.busy, 0);
    check("abort_front", bus.frontBank, 0);
    check("abort_pend",  bus.swapPending, 0);
    // Bank 0 is now the front bank
    for (int a = 0; a < DEPTH; a++) begin
      bus.displayAddress = ADDR_W'(a);
      tick();
      check($sformatf("abort_word_%0d", a), bus.displayDataOut,
            (a < 4) ? 32'h0AA : 32'(9'h040 + a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
